// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, mem, writeback.
// Ports: imem_*/dmem_* req/gnt/rvalid buses, decoder fields in, rf_we/wb_sel/pc/retired/bus_error out.
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [4:0]  alu_control,
    input  logic [2:0]  load_control,
    input  logic [2:0]  store_control,
    input  logic [2:0]  branch_control,
    input  logic [1:0]  jump_control,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic        retired,
    output logic        bus_error
);

    localparam logic [4:0]  ALU_NOP   = 5'd0;
    localparam logic [2:0]  LD_NOP    = 3'd0;
    localparam logic [2:0]  STR_NOP   = 3'd0;
    localparam logic [2:0]  BR_NOP    = 3'd0;
    localparam logic [1:0]  JMP_NOP   = 2'd0;
    localparam logic [1:0]  JMP_JAL   = 2'd1;
    localparam logic [1:0]  JMP_JALR  = 2'd2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [7:0]  TO_LAST   = 8'(MEM_TIMEOUT - 32'd1);

    typedef enum logic [2:0] {
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXECUTE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WRITEBACK,
        S_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, npc_q, npc_d, instr_q;
    logic [7:0]  cnt_q;
    logic        imem_req_q, dmem_req_q, dmem_we_q;
    logic        rf_we_q, retired_q, bus_error_q;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic        is_load, is_store, is_branch, is_jump;
    logic        is_mem, wr_en, waiting, timeout;

    assign is_load   = load_control != LD_NOP;
    assign is_store  = store_control != STR_NOP;
    assign is_branch = branch_control != BR_NOP;
    assign is_jump   = jump_control != JMP_NOP;
    assign is_mem    = is_load | is_store;

    // Stores and branches never write the register file, even when the
    // decoder reports an ALU op for address or compare computation.
    assign wr_en = (is_load | is_jump | (alu_control != ALU_NOP))
                   & ~is_store & ~is_branch;

    assign waiting = state_q inside {S_FETCH_REQ, S_FETCH_WAIT,
                                     S_MEM_REQ, S_MEM_WAIT};
    assign timeout = cnt_q == TO_LAST;

    always_comb begin
        wb_sel_d = 2'd0;
        if (is_load) begin
            wb_sel_d = 2'd1;
        end else if (is_jump) begin
            wb_sel_d = 2'd2;
        end
    end

    always_comb begin
        npc_d = pc_q + 32'd4;
        if (is_branch && branch_taken) begin
            npc_d = pc_q + imm;
        end else if (jump_control == JMP_JAL) begin
            npc_d = pc_q + imm;
        end else if (jump_control == JMP_JALR) begin
            npc_d = alu_result & ~32'h1;
        end
    end

    // Handshake progress wins over timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH_REQ: begin
                if (imem_gnt) state_d = S_FETCH_WAIT;
                else if (timeout) state_d = S_ERROR;
            end
            S_FETCH_WAIT: begin
                if (imem_rvalid) state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = is_mem ? S_MEM_REQ : S_WRITEBACK;
            S_MEM_REQ: begin
                if (dmem_gnt) state_d = S_MEM_WAIT;
                else if (timeout) state_d = S_ERROR;
            end
            S_MEM_WAIT: begin
                if (dmem_rvalid) state_d = S_WRITEBACK;
                else if (timeout) state_d = S_ERROR;
            end
            S_WRITEBACK: state_d = S_FETCH_REQ;
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_ERROR;
        endcase
    end

    // Outputs are registered from the next state so each one is a clean
    // Moore output of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH_REQ;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC;
            instr_q     <= NOP_INSTR;
            cnt_q       <= 8'd0;
            imem_req_q  <= 1'b1;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            rf_we_q     <= 1'b0;
            wb_sel_q    <= 2'd0;
            retired_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || !waiting) begin
                cnt_q <= 8'd0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == S_FETCH_WAIT && imem_rvalid) begin
                instr_q <= imem_rdata;
            end
            if (state_q == S_EXECUTE) begin
                npc_q <= npc_d;
            end
            if (state_q == S_WRITEBACK) begin
                pc_q <= npc_q;
            end
            imem_req_q  <= state_d == S_FETCH_REQ;
            dmem_req_q  <= state_d == S_MEM_REQ;
            dmem_we_q   <= (state_d == S_MEM_REQ) && is_store;
            rf_we_q     <= (state_d == S_WRITEBACK) && wr_en;
            wb_sel_q    <= (state_d == S_WRITEBACK) ? wb_sel_d : 2'd0;
            retired_q   <= state_d == S_WRITEBACK;
            bus_error_q <= state_d == S_ERROR;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign wb_sel    = wb_sel_q;
    assign pc        = pc_q;
    assign retired   = retired_q;
    assign bus_error = bus_error_q;

endmodule
